// File: rtl/dot_matrix_scan.sv
// dot_matrix_scan: reads glyph rows from the character ROM and multiplexes them
// onto an 8x8 LED dot matrix (rows active-low, columns active-high).
// Scan order per row: FETCH (1 cycle) -> SHOW (ROW_CYC) -> BLANK (BLANK_CYC).
// The glyph is latched only at frame boundaries so a character is never torn.
// Optional feature: define BLINK_EN to enable frame-based blinking driven by blink_i.
// With BLINK_EN undefined, blink_i is ignored and every frame is lit.
module dot_matrix_scan #(
  parameter int unsigned ROW_CYC      = 1000,
  parameter int unsigned BLANK_CYC    = 2,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic [3:0] glyph_sel_i,
  input  logic       blink_i,
  output logic [6:0] rom_addr_o,
  input  logic [7:0] rom_data_i,
  output logic [7:0] row_n_o,
  output logic [7:0] col_o,
  output logic       frame_done_o
);

  localparam int unsigned MaxCyc = (ROW_CYC > BLANK_CYC) ? ROW_CYC : BLANK_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [CntW-1:0] ShowLast  = CntW'(ROW_CYC - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StShow, StBlank} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      row_q;
  logic [3:0]      glyph_q;
  logic [6:0]      rom_addr_q;
  logic [7:0]      row_n_q;
  logic [7:0]      col_q;
  logic            frame_done_q;

  logic [3:0] glyph_clean;
  logic       frame_end;
  logic       dark;

  // Out-of-range glyph indices select the null glyph.
  always_comb begin
    glyph_clean = (glyph_sel_i > 4'd9) ? 4'd0 : glyph_sel_i;
  end

  // Last BLANK cycle of row 7 with the scan still enabled: a frame completes here.
  always_comb begin
    frame_end = enable_i && (state_q == StBlank) && (cnt_q == BlankLast) && (row_q == 3'd7);
  end

`ifdef BLINK_EN
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);

  logic [BlinkW-1:0] blink_cnt_q;
  logic              dark_q;

  // Count completed frames and flip lit/dark every BLINK_FRAMES frames while blinking.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      blink_cnt_q <= '0;
      dark_q      <= 1'b0;
    end else if (!blink_i) begin
      blink_cnt_q <= '0;
      // Dark frame in progress finishes; the next frame is lit.
      if (frame_end) dark_q <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_q <= '0;
        dark_q      <= ~dark_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    dark = dark_q;
  end
`else
  logic unused_blink;
  localparam int unsigned UnusedBlinkFrames = BLINK_FRAMES;

  // Blinking is not built; every frame is lit.
  always_comb begin
    dark         = 1'b0;
    unused_blink = blink_i ^ (UnusedBlinkFrames == 0);
  end
`endif

  // Scan FSM with registered outputs: row_n and col always change on the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      row_q        <= 3'd0;
      glyph_q      <= 4'd0;
      rom_addr_q   <= 7'd0;
      row_n_q      <= 8'hFF;
      col_q        <= 8'h00;
      frame_done_q <= 1'b0;
    end else if ((state_q != StIdle) && !enable_i) begin
      // Abandon the partial frame; no frame_done for it.
      state_q      <= StIdle;
      cnt_q        <= '0;
      row_n_q      <= 8'hFF;
      col_q        <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          row_n_q <= 8'hFF;
          col_q   <= 8'h00;
          cnt_q   <= '0;
          if (enable_i) begin
            glyph_q    <= glyph_clean;
            row_q      <= 3'd0;
            rom_addr_q <= {glyph_clean, 3'd0};
            state_q    <= StFetch;
          end
        end
        StFetch: begin
          // rom_addr has been stable for this cycle, so rom_data is valid now.
          col_q   <= dark ? 8'h00 : rom_data_i;
          row_n_q <= ~(8'b1 << row_q);
          cnt_q   <= '0;
          state_q <= StShow;
        end
        StShow: begin
          if (cnt_q == ShowLast) begin
            row_n_q <= 8'hFF;
            col_q   <= 8'h00;
            cnt_q   <= '0;
            state_q <= StBlank;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            cnt_q   <= '0;
            state_q <= StFetch;
            if (row_q == 3'd7) begin
              row_q        <= 3'd0;
              glyph_q      <= glyph_clean;
              rom_addr_q   <= {glyph_clean, 3'd0};
              frame_done_q <= 1'b1;
            end else begin
              row_q      <= row_q + 3'd1;
              rom_addr_q <= {glyph_q, row_q + 3'd1};
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          row_n_q <= 8'hFF;
          col_q   <= 8'h00;
        end
      endcase
    end
  end

  assign rom_addr_o   = rom_addr_q;
  assign row_n_o      = row_n_q;
  assign col_o        = col_q;
  assign frame_done_o = frame_done_q;

endmodule
